vector_search_ctrl: RTL and testbench
=====================================

# vector_search_ctrl

Sequencer for the vector-similarity search engine. On a `start_search` pulse from the AXI register block, it walks the vector store and streams each stored vector, word by word, into the scoring datapath. It collects the returned scores and reports the best-scoring vector as `winner_id` / `max_score`. While a search runs it also blocks register-side writes to the vector store, so the memory is never modified mid-scan.

## Interface
Parameters:
- `WORDS_PER_VEC`, default 4: 64-bit words per vector; fixed at 4 so that `{vec_id[7:0], word[1:0]}` forms the 10-bit store address.
- `VEC_W`, default 8: vector index width; up to 256 vectors.

Ports (clock and reset are fixed as one clock, async active-low reset):
- `s_axi_aclk`  in  1  single clock; all logic is on the rising edge.
- `s_axi_aresetn`  in  1  asynchronous, active-low reset.
- `start_search`  in  1  one-cycle start pulse from the register block.
- `num_vectors`  in  9  number of vectors to scan, 0..256; sampled on the accepted start.
- `write_en`  in  1  store write request from the register block.
- `mem_wr_en`  out  1  gated store write strobe; equals `write_en & ~busy`.
- `wr_blocked`  out  1  sticky flag, set when `write_en` arrives while busy; cleared by the next accepted start.
- `mem_rd_en`  out  1  store read strobe.
- `mem_rd_addr`  out  10  store read address.
- `mem_rd_data`  in  64  store read data; valid 1 cycle after `mem_rd_en`.
- `sc_valid`, `sc_first`, `sc_last`  out  1 each  word strobe and vector framing to the score unit.
- `sc_data`  out  64  word to the score unit.
- `sc_id`  out  8  vector tag for the word.
- `sc_score_valid`  in  1  score result strobe.
- `sc_score`  in  32  unsigned score.
- `sc_score_id`  in  8  tag of the returned score.
- `busy`  out  1  high from the accepted start until `done`.
- `done`  out  1  one-cycle completion pulse.
- `winner_id`  out  8  best vector tag.
- `max_score`  out  32  best score.

## Operation
- FSM states and transitions:
  - IDLE: `start_search` → FETCH; if `num_vectors==0` → DONE instead.
  - FETCH: one read per cycle. When the last word of the last vector is issued → DRAIN.
  - DRAIN: when the received-score count equals `num_vectors` → DONE.
  - DONE: asserts `done` for one cycle, then → IDLE.
- Address generation: a vector counter and a 2-bit word counter; `mem_rd_addr = {vec_cnt, word_cnt}`. The word counter wraps 3→0 and increments the vector counter.
- Score stream: `sc_valid/first/last/id` are `mem_rd_en` and its framing delayed 1 cycle; `sc_data = mem_rd_data`. There is no backpressure; the score unit accepts every cycle.
- Score tracking:
  - The first score of a run is always taken.
  - After that, replace only on strictly greater. On equal scores the earlier arrival is kept.
  - Scores are unsigned, 32-bit compare.
- Start handling:
  - `start_search` while busy is ignored.
  - An accepted start clears `winner_id`, `max_score`, the counters and `wr_blocked`.
- Result hold: `winner_id` / `max_score` hold their values after `done` until the next accepted start.
- Spurious scores: `sc_score_valid` in IDLE is ignored.
- Reset: an asynchronous reset mid-search returns to IDLE immediately. No `done` pulse is issued.
- Reset values: all outputs 0.

## Timing
- Accepted start at cycle 0: first `mem_rd_en` is at cycle 1 and `busy` rises at cycle 1.
- Last read at cycle 4·N; last `sc_valid` at 4·N+1.
- `done` is 1 cycle after the final `sc_score_valid` is registered. `busy` falls in the same cycle `done` is high.
- Back-to-back: the earliest new start is accepted in the cycle after `done`.
- `num_vectors==0`: `done` at cycle 1, `busy` never asserted, and results stay at 0.
- `mem_wr_en` is combinational from `write_en` and registered `busy`.

## Configuration
- Macro `VSEARCH_THRESHOLD_EN` defined:
  - Adds input `score_thresh[31:0]`, sampled at start, and output `no_match`.
  - Only scores `>= score_thresh` are candidates.
  - If none qualify: `no_match=1` at `done`, and `winner_id`/`max_score` stay 0.
  - `no_match` is cleared on the next start.
- Macro undefined: the port and the output are absent, and every score is a candidate.

## Structure
- Package `vsearch_pkg`:
  - FSM state encoding.
  - `WORDS_PER_VEC`, `VEC_W`, `ADDR_W=10`, `SCORE_W=32`.
- Sub-module `vsearch_max_tracker`: holds the running max/winner, the first-score flag and the optional threshold compare.
- The controller top holds the FSM, address and framing generation, the score counter and write gating.

## Test plan
- `num_vectors=3`, scores 10, 50, 20 → addresses 0..11 read in order; `winner_id=1`, `max_score=50`; `done` is 1 cycle after the 3rd score.
- Scores 7, 7, 7 → `winner_id=0` (tie keeps the first).
- `num_vectors=0` → `done` at cycle 1, `busy` stays 0, results 0.
- `write_en` during a search → `mem_wr_en=0`, `wr_blocked=1`; after `done`, `write_en` → `mem_wr_en=1`; next start clears `wr_blocked`.
- Second `start_search` mid-scan ignored; `s_axi_aresetn` low at mid-FETCH → IDLE, all outputs 0, no `done`.
- With `VSEARCH_THRESHOLD_EN`, `score_thresh=100`, scores 40 and 90 → `no_match=1`, `winner_id=0`. Then `score_thresh=60` → `winner_id=1`, `max_score=90`.

Source files
------------

// File: rtl/vsearch_pkg.sv
// vsearch_pkg
// Shared definitions for the vector-search sequencer: the store geometry,
// the score width and the controller FSM state encoding.
package vsearch_pkg;

  localparam int WORDS_PER_VEC = 4;
  localparam int VEC_W         = 8;
  localparam int ADDR_W        = 10;
  localparam int SCORE_W       = 32;
  localparam int DATA_W        = 64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } vs_state_e;

endpackage

// File: rtl/vsearch_max_tracker.sv
// vsearch_max_tracker
// Keeps the running best score and the tag of the vector that produced it.
// The first candidate of a run is always taken; afterwards only a strictly
// greater score replaces the held one, so on ties the earliest arrival wins.
//
// Optional feature (macro VSEARCH_THRESHOLD_EN): a threshold sampled on
// i_clear; only scores >= threshold are candidates, and o_have_first tells
// the controller whether any candidate was seen.
//
// Ports:
//   i_clk, i_rst_n   clock, async active-low reset
//   i_clear          start of a new run: clears results (and samples i_thresh)
//   i_score_valid    accepted score strobe
//   i_score          unsigned score
//   i_score_id       tag of the score
//   i_thresh         candidate threshold (VSEARCH_THRESHOLD_EN only)
//   o_winner_id      tag of the best score so far
//   o_max_score      best score so far
//   o_have_first     a candidate has been taken this run (VSEARCH_THRESHOLD_EN only)
module vsearch_max_tracker
  import vsearch_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_clear,
  input  logic               i_score_valid,
  input  logic [SCORE_W-1:0] i_score,
  input  logic [VEC_W-1:0]   i_score_id,
`ifdef VSEARCH_THRESHOLD_EN
  input  logic [SCORE_W-1:0] i_thresh,
  output logic               o_have_first,
`endif
  output logic [VEC_W-1:0]   o_winner_id,
  output logic [SCORE_W-1:0] o_max_score
);

  logic [VEC_W-1:0]   r_winner_id;
  logic [SCORE_W-1:0] r_max_score;
  logic               r_have_first;
  logic               w_candidate;
  logic               w_take;

`ifdef VSEARCH_THRESHOLD_EN
  logic [SCORE_W-1:0] r_thresh;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_thresh <= '0;
    end else if (i_clear) begin
      r_thresh <= i_thresh;
    end
  end

  assign w_candidate  = (i_score >= r_thresh);
  assign o_have_first = r_have_first;
`else
  assign w_candidate = 1'b1;
`endif

  assign w_take = i_score_valid & w_candidate & (~r_have_first | (i_score > r_max_score));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_winner_id  <= '0;
      r_max_score  <= '0;
      r_have_first <= 1'b0;
    end else if (i_clear) begin
      r_winner_id  <= '0;
      r_max_score  <= '0;
      r_have_first <= 1'b0;
    end else if (w_take) begin
      r_winner_id  <= i_score_id;
      r_max_score  <= i_score;
      r_have_first <= 1'b1;
    end
  end

  assign o_winner_id = r_winner_id;
  assign o_max_score = r_max_score;

endmodule

// File: rtl/vector_search_ctrl.sv
// vector_search_ctrl
// Sequencer for the vector-similarity search engine. A start pulse walks the
// vector store one 64-bit word per cycle, streams the words with vector
// framing to the score unit, counts the returned scores, and reports the best
// vector once every score is back. Register-side store writes are blocked
// while a search runs.
//
// Optional feature: define VSEARCH_THRESHOLD_EN to add the score_thresh input
// and the no_match output.
//
// Ports:
//   s_axi_aclk, s_axi_aresetn   clock, async active-low reset
//   start_search, num_vectors   start pulse and vector count (0..256)
//   write_en, mem_wr_en         store write request and its gated strobe
//   wr_blocked                  sticky: a write arrived while busy
//   mem_rd_en/addr/data         store read port (data 1 cycle after en)
//   sc_valid/first/last/id/data word stream to the score unit
//   sc_score_valid/score/id     score results from the score unit
//   busy, done                  run status, one-cycle completion pulse
//   winner_id, max_score        best vector of the last run
//   score_thresh, no_match      threshold and "nothing qualified" (macro only)
//
// state  | meaning
// IDLE   | waiting for an accepted start
// FETCH  | one store read per cycle, word by word, vector by vector
// DRAIN  | all reads issued, waiting for the remaining scores
// DONE   | one-cycle completion pulse, then back to IDLE
module vector_search_ctrl #(
  parameter int WORDS_PER_VEC = vsearch_pkg::WORDS_PER_VEC,
  parameter int VEC_W         = vsearch_pkg::VEC_W
) (
  input  logic                             s_axi_aclk,
  input  logic                             s_axi_aresetn,
  input  logic                             start_search,
  input  logic [VEC_W:0]                   num_vectors,
  input  logic                             write_en,
  output logic                             mem_wr_en,
  output logic                             wr_blocked,
  output logic                             mem_rd_en,
  output logic [vsearch_pkg::ADDR_W-1:0]   mem_rd_addr,
  input  logic [vsearch_pkg::DATA_W-1:0]   mem_rd_data,
  output logic                             sc_valid,
  output logic                             sc_first,
  output logic                             sc_last,
  output logic [vsearch_pkg::DATA_W-1:0]   sc_data,
  output logic [VEC_W-1:0]                 sc_id,
  input  logic                             sc_score_valid,
  input  logic [vsearch_pkg::SCORE_W-1:0]  sc_score,
  input  logic [VEC_W-1:0]                 sc_score_id,
`ifdef VSEARCH_THRESHOLD_EN
  input  logic [vsearch_pkg::SCORE_W-1:0]  score_thresh,
  output logic                             no_match,
`endif
  output logic                             busy,
  output logic                             done,
  output logic [VEC_W-1:0]                 winner_id,
  output logic [vsearch_pkg::SCORE_W-1:0]  max_score
);

  import vsearch_pkg::*;

  localparam int WORD_W = $clog2(WORDS_PER_VEC);

  vs_state_e          r_state;
  vs_state_e          w_state_nxt;
  logic               w_start_ok;
  logic               w_rd_en;
  logic               w_done;

  logic [VEC_W-1:0]   r_vec_cnt;
  logic [WORD_W-1:0]  r_word_cnt;
  logic [VEC_W:0]     r_num;
  logic [VEC_W:0]     r_score_cnt;
  logic [VEC_W:0]     w_score_cnt_nxt;
  logic               w_score_acc;
  logic               w_last_word_of_vec;
  logic               w_last_word;

  logic               r_busy;
  logic               r_wr_blocked;
  logic               r_sc_valid;
  logic               r_sc_first;
  logic               r_sc_last;
  logic [VEC_W-1:0]   r_sc_id;

  assign w_last_word_of_vec = (r_word_cnt == WORD_W'(WORDS_PER_VEC - 1));
  assign w_last_word        = w_last_word_of_vec &&
                              ({1'b0, r_vec_cnt} == (r_num - (VEC_W+1)'(1)));

  // Scores only count while a run is active; stray results in IDLE/DONE
  // must neither advance the count nor disturb the held result.
  assign w_score_acc     = sc_score_valid & r_busy;
  assign w_score_cnt_nxt = r_score_cnt + (VEC_W+1)'(w_score_acc);

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start_ok  = 1'b0;
    w_rd_en     = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start_search) begin
          w_start_ok  = 1'b1;
          w_state_nxt = (num_vectors == '0) ? ST_DONE : ST_FETCH;
        end
      end
      ST_FETCH: begin
        w_rd_en = 1'b1;
        if (w_last_word) begin
          w_state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // Include a score arriving this cycle so done lands one cycle after it.
        if (w_score_cnt_nxt == r_num) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        w_done      = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      r_vec_cnt   <= '0;
      r_word_cnt  <= '0;
      r_num       <= '0;
      r_score_cnt <= '0;
    end else if (w_start_ok) begin
      r_vec_cnt   <= '0;
      r_word_cnt  <= '0;
      r_num       <= num_vectors;
      r_score_cnt <= '0;
    end else begin
      if (w_rd_en) begin
        r_word_cnt <= r_word_cnt + WORD_W'(1);
        if (w_last_word_of_vec) begin
          r_vec_cnt <= r_vec_cnt + VEC_W'(1);
        end
      end
      if (w_score_acc) begin
        r_score_cnt <= w_score_cnt_nxt;
      end
    end
  end

  // busy is registered from the next state so it rises with the first read
  // and is already low in the DONE cycle.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      r_busy       <= 1'b0;
      r_wr_blocked <= 1'b0;
    end else begin
      r_busy <= (w_state_nxt == ST_FETCH) || (w_state_nxt == ST_DRAIN);
      if (w_start_ok) begin
        r_wr_blocked <= 1'b0;
      end else if (write_en && r_busy) begin
        r_wr_blocked <= 1'b1;
      end
    end
  end

  // Framing follows the read by one cycle to line up with the store data.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      r_sc_valid <= 1'b0;
      r_sc_first <= 1'b0;
      r_sc_last  <= 1'b0;
      r_sc_id    <= '0;
    end else begin
      r_sc_valid <= w_rd_en;
      r_sc_first <= w_rd_en & (r_word_cnt == '0);
      r_sc_last  <= w_rd_en & w_last_word_of_vec;
      r_sc_id    <= w_rd_en ? r_vec_cnt : '0;
    end
  end

`ifdef VSEARCH_THRESHOLD_EN
  logic w_have_first;
  logic r_no_match;

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      r_no_match <= 1'b0;
    end else if (w_start_ok) begin
      r_no_match <= 1'b0;
    end else if (r_state == ST_DONE) begin
      r_no_match <= ~w_have_first;
    end
  end

  // Visible in the done cycle itself, then held by r_no_match.
  assign no_match = r_no_match | ((r_state == ST_DONE) & ~w_have_first);
`endif

  vsearch_max_tracker u_tracker (
    .i_clk         (s_axi_aclk),
    .i_rst_n       (s_axi_aresetn),
    .i_clear       (w_start_ok),
    .i_score_valid (w_score_acc),
    .i_score       (sc_score),
    .i_score_id    (sc_score_id),
`ifdef VSEARCH_THRESHOLD_EN
    .i_thresh      (score_thresh),
    .o_have_first  (w_have_first),
`endif
    .o_winner_id   (winner_id),
    .o_max_score   (max_score)
  );

  assign mem_wr_en   = write_en & ~r_busy;
  assign wr_blocked  = r_wr_blocked;
  assign mem_rd_en   = w_rd_en;
  assign mem_rd_addr = {r_vec_cnt, r_word_cnt};
  assign sc_valid    = r_sc_valid;
  assign sc_first    = r_sc_first;
  assign sc_last     = r_sc_last;
  assign sc_id       = r_sc_id;
  assign sc_data     = r_sc_valid ? mem_rd_data : '0;
  assign busy        = r_busy;
  assign done        = w_done;

endmodule

// File: tb/tb_vector_search_ctrl.sv
module tb_vector_search_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_search = 1'b0;
  logic [8:0]  num_vectors = '0;
  logic        write_en = 1'b0;
  logic        mem_wr_en, wr_blocked, mem_rd_en;
  logic [9:0]  mem_rd_addr;
  logic [63:0] mem_rd_data = '0;
  logic        sc_valid, sc_first, sc_last;
  logic [63:0] sc_data;
  logic [7:0]  sc_id;
  logic        sc_score_valid = 1'b0;
  logic [31:0] sc_score = '0;
  logic [7:0]  sc_score_id = '0;
  logic        busy, done;
  logic [7:0]  winner_id;
  logic [31:0] max_score;
`ifdef VSEARCH_THRESHOLD_EN
  logic [31:0] score_thresh = '0;
  logic        no_match;
  logic [31:0] thr_run = '0;
`endif

  always #5 clk = ~clk;

  vector_search_ctrl dut (
    .s_axi_aclk     (clk),
    .s_axi_aresetn  (rst_n),
    .start_search   (start_search),
    .num_vectors    (num_vectors),
    .write_en       (write_en),
    .mem_wr_en      (mem_wr_en),
    .wr_blocked     (wr_blocked),
    .mem_rd_en      (mem_rd_en),
    .mem_rd_addr    (mem_rd_addr),
    .mem_rd_data    (mem_rd_data),
    .sc_valid       (sc_valid),
    .sc_first       (sc_first),
    .sc_last        (sc_last),
    .sc_data        (sc_data),
    .sc_id          (sc_id),
    .sc_score_valid (sc_score_valid),
    .sc_score       (sc_score),
    .sc_score_id    (sc_score_id),
`ifdef VSEARCH_THRESHOLD_EN
    .score_thresh   (score_thresh),
    .no_match       (no_match),
`endif
    .busy           (busy),
    .done           (done),
    .winner_id      (winner_id),
    .max_score      (max_score)
  );

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;

  // Run description owned by the main stimulus process.
  bit          run_valid = 1'b0;
  int          c0 = 0;
  int          n = 0;
  int          done_cyc = 0;
  int          spur_cyc = -100;
  logic [31:0] tab [0:7];
  logic [31:0] stg [0:7];

  // Owned by the compare process.
  bit exp_wrb = 1'b0;
  int seen_done_cyc = -1;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] fmem(int a);
    logic [15:0] a16;
    a16 = 16'(a);
    return {16'hC0DE, a16, 16'h5A5A, ~a16};
  endfunction

  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= fmem(int'(mem_rd_addr));
  end

  task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got !== exp)
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, got, exp);
    else
      n_pass++;
  endtask

  // Score unit: returns the score of vector v at cycle c0+4v+7.
  always @(posedge clk) begin : score_unit
    int d;
    #1;
    sc_score_valid = 1'b0;
    sc_score       = '0;
    sc_score_id    = '0;
    if (run_valid && n > 0 && cyc >= c0 + 7) begin
      d = cyc - c0 - 7;
      if (d % 4 == 0 && d / 4 < n) begin
        sc_score_valid = 1'b1;
        sc_score       = tab[d/4];
        sc_score_id    = 8'(d / 4);
      end
    end
    if (cyc == spur_cyc) begin
      sc_score_valid = 1'b1;
      sc_score       = 32'hFFFF_FFFF;
      sc_score_id    = 8'd9;
    end
  end

  // Per-cycle comparison against the behavioural model.
  always @(negedge clk) begin : compare
    bit          e_rd, e_scv, e_busy, e_done, e_cand, e_any;
    int          k, idx;
    logic [7:0]  e_win;
    logic [31:0] e_max;
    e_rd = 0; e_scv = 0; e_busy = 0; e_done = 0; e_any = 0;
    e_win = '0; e_max = '0; idx = 0;
    if (run_valid) begin
      e_rd   = (cyc >= c0 + 1) && (cyc <= c0 + 4*n);
      e_scv  = (cyc >= c0 + 2) && (cyc <= c0 + 4*n + 1);
      e_busy = (n > 0) && (cyc >= c0 + 1) && (cyc < done_cyc);
      e_done = (cyc == done_cyc);
      k = 0;
      for (int v = 0; v < n; v++)
        if (c0 + 4*v + 7 <= cyc - 1) k++;
      for (int v = 0; v < k; v++) begin
`ifdef VSEARCH_THRESHOLD_EN
        e_cand = (tab[v] >= thr_run);
`else
        e_cand = 1'b1;
`endif
        if (e_cand && (!e_any || tab[v] > e_max)) begin
          e_any = 1; e_max = tab[v]; e_win = 8'(v);
        end
      end
    end
    chk("mem_rd_en", mem_rd_en, e_rd);
    chk("sc_valid", sc_valid, e_scv);
    chk("busy", busy, e_busy);
    chk("done", done, e_done);
    chk("mem_wr_en", mem_wr_en, write_en & ~e_busy);
    chk("wr_blocked", wr_blocked, exp_wrb);
    if (e_rd) chk("mem_rd_addr", mem_rd_addr, 64'(cyc - c0 - 1));
    if (e_scv) begin
      idx = cyc - c0 - 2;
      chk("sc_data", sc_data, fmem(idx));
      chk("sc_first", sc_first, idx % 4 == 0);
      chk("sc_last", sc_last, idx % 4 == 3);
      chk("sc_id", sc_id, 64'(idx / 4));
    end
    if (!run_valid) begin
      chk("rst_addr", mem_rd_addr, 0);
      chk("rst_sc_data", sc_data, 0);
      chk("rst_sc_frame", {sc_first, sc_last, sc_id}, 0);
    end
    if (!run_valid || cyc > c0) begin
      chk("winner_id", winner_id, e_win);
      chk("max_score", max_score, e_max);
`ifdef VSEARCH_THRESHOLD_EN
      chk("no_match", no_match, run_valid && cyc >= done_cyc && !e_any);
`endif
    end
    if (done) seen_done_cyc = cyc;
    if (!rst_n) exp_wrb = 0;
    else if (run_valid && cyc == c0) exp_wrb = 0;
    else if (write_en && e_busy) exp_wrb = 1;
  end

  task automatic tick(int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic load(logic [31:0] s0, logic [31:0] s1, logic [31:0] s2, logic [31:0] s3);
    stg[0] = s0; stg[1] = s1; stg[2] = s2; stg[3] = s3;
  endtask

  // Starts a run; the model records it only if the controller must accept it.
  task automatic start(int nv);
    start_search = 1'b1;
    num_vectors  = 9'(nv);
    if (!run_valid || cyc > done_cyc) begin
      for (int i = 0; i < 8; i++) tab[i] = stg[i];
`ifdef VSEARCH_THRESHOLD_EN
      thr_run = score_thresh;
`endif
      c0 = cyc;
      n = nv;
      done_cyc = (nv == 0) ? cyc + 1 : cyc + 4*nv + 4;
      run_valid = 1'b1;
    end
    tick(1);
    start_search = 1'b0;
  endtask

  task automatic wait_after_done();
    while (cyc <= done_cyc) tick(1);
  endtask

  initial begin
    int saved_done;
    for (int i = 0; i < 8; i++) begin stg[i] = '0; tab[i] = '0; end
    tick(3);
    rst_n = 1'b1;
    tick(2);

    // Scores 10, 50, 20: vector 1 wins, done 16 cycles after start.
    load(10, 50, 20, 0);
    start(3);
    chk("first_read_cycle1", mem_rd_en, 1);
    chk("busy_cycle1", busy, 1);
    tick(20);
    chk("t1_done_latency", seen_done_cyc - c0, 16);
    chk("t1_winner", winner_id, 1);
    chk("t1_max", max_score, 50);

    // Tie 7,7,7 keeps vector 0; next start lands the cycle after done.
    load(7, 7, 7, 0);
    start(3);
    wait_after_done();
    chk("t2_winner", winner_id, 0);
    chk("t2_max", max_score, 7);

    // Unsigned compare, later equal max not taken; write and start while busy.
    load(32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    start(4);
    tick(3);
    write_en = 1'b1;
    tick(1);
    write_en = 1'b0;
    tick(1);
    chk("t3_wr_blocked", wr_blocked, 1);
    start(2);
    wait_after_done();
    tick(2);
    chk("t3_winner", winner_id, 2);
    chk("t3_max", max_score, 32'hFFFF_FFFF);
    chk("t3_wr_blocked_held", wr_blocked, 1);
    write_en = 1'b1;
    #2;
    chk("t3_wr_idle", mem_wr_en, 1);
    tick(1);
    write_en = 1'b0;

    // Stray score in IDLE must not change the result.
    spur_cyc = cyc + 2;
    tick(5);
    chk("spurious_winner", winner_id, 2);
    chk("spurious_max", max_score, 32'hFFFF_FFFF);

    // Zero vectors: done at cycle 1, results cleared, wr_blocked cleared.
    start(0);
    tick(4);
    chk("t4_done_latency", seen_done_cyc - c0, 1);
    chk("t4_winner", winner_id, 0);
    chk("t4_max", max_score, 0);
    chk("t4_wr_blocked", wr_blocked, 0);

    load(5, 9, 9, 3);
    start(4);
    wait_after_done();
    chk("t5_winner", winner_id, 1);
    chk("t5_max", max_score, 9);

    // Reset in the middle of FETCH: back to idle, no done.
    load(1, 2, 3, 0);
    start(3);
    tick(5);
    saved_done = seen_done_cyc;
    rst_n = 1'b0;
    run_valid = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(20);
    chk("t6_no_done", seen_done_cyc, saved_done);
    chk("t6_busy", busy, 0);

    load(42, 0, 0, 0);
    start(1);
    wait_after_done();
    chk("t7_winner", winner_id, 0);
    chk("t7_max", max_score, 42);

`ifdef VSEARCH_THRESHOLD_EN
    score_thresh = 100;
    load(40, 90, 0, 0);
    start(2);
    wait_after_done();
    chk("th1_no_match", no_match, 1);
    chk("th1_winner", winner_id, 0);
    chk("th1_max", max_score, 0);
    score_thresh = 60;
    start(2);
    wait_after_done();
    chk("th2_no_match", no_match, 0);
    chk("th2_winner", winner_id, 1);
    chk("th2_max", max_score, 90);
`endif

    tick(3);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
